alu_share_arb: RTL and testbench
================================

// Module: alu_share_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing one combinational 32-bit ALU among NUM_REQ requesters.
//  Accepts an operation on a valid/ready handshake and drives the ALU from registered operands.
//  Captures the ALU result and returns it to the owning requester on a valid/ready response.
//  Sits between the core's execute/AGU/CSR-side users and a single external ALU instance.
// PARAMETERS
//  NUM_REQ  2   number of requesters (>=2); requester i owns bits [i*32 +: 32] / [i*4 +: 4]
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           synchronous reset, active low
//  req_valid  in   NUM_REQ     request valid per requester
//  req_ready  out  NUM_REQ     request accepted (one-hot or zero)
//  req_in1    in   NUM_REQ*32  operand 1 per requester
//  req_in2    in   NUM_REQ*32  operand 2 per requester
//  req_aluop  in   NUM_REQ*4   ALU opcode per requester
//  rsp_valid  out  NUM_REQ     response valid, one-hot to owner
//  rsp_ready  in   NUM_REQ     response accepted per requester
//  rsp_data   out  32          result of the owned operation
//  alu_in1    out  32          to ALU operand 1
//  alu_in2    out  32          to ALU operand 2
//  alu_aluop  out  4           to ALU opcode
//  alu_out    in   32          from ALU result (combinational)
// BEHAVIOUR
//  One clock (clk); reset synchronous, active low (rst_n).
//  Reset: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, alu_in1/in2=0, alu_aluop=0 (ADD), rr_ptr=0, owner=0.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: grant = first i with req_valid[i], searching from rr_ptr upward mod NUM_REQ; req_ready[grant]=1
//   (combinational, valid-dependent). On handshake: latch in1/in2/aluop/owner, ->EXEC. No valid: stay.
//  EXEC: alu_* driven from latched regs (registered, stable all cycle); at clock edge rsp_data<=alu_out, ->RESP.
//  RESP: rsp_valid[owner]=1, rsp_data stable until rsp_ready[owner]; on handshake rr_ptr<=(owner+1)%NUM_REQ, ->IDLE.
//  Latency: accept at cycle N -> rsp_valid at N+2. Base throughput: one op per 3 cycles.
//  req_ready=0 in EXEC and RESP (base). Requesters hold req_* stable while valid && !ready.
//  Opcodes passed unchanged, no checking: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011,
//   XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111. Undefined codes: rsp_data = whatever ALU returns.
//  rsp_ready on non-owner bits ignored; rsp_ready in IDLE/EXEC ignored.
//  Simultaneous valids: exactly one grant; losers wait, priority rotates only on completed response.
//  Reset mid-op (any state): in-flight op discarded, no response issued, rr_ptr=0.
//  Never more than one bit set in req_ready or rsp_valid.
// CONFIGURATION
//  ALU_B2B_EN defined: in RESP, in the cycle rsp_ready[owner]=1, arbitration runs using the updated
//   pointer ((owner+1)%NUM_REQ); a granted request is accepted that cycle, ->EXEC directly (skip IDLE).
//   Throughput: one op per 2 cycles. Adds combinational path rsp_ready->req_ready.
//  ALU_B2B_EN undefined: req_ready=0 in RESP; always returns to IDLE; one op per 3 cycles.
// STRUCTURE
//  Shared package alu_pkg: ALU opcode localparams (ALU_ADD..ALU_AND above), FSM state encoding
//   (IDLE/EXEC/RESP), data width constant XLEN=32.
//  One sub-module: rr_pick (NUM_REQ-wide combinational round-robin picker: valid, ptr -> one-hot grant,
//   any_grant). Top holds FSM, operand/result registers, pointer.
// TESTING
//  1 req0 ADD 5,7 from IDLE -> req_ready=01 same cycle; rsp_valid=01 two cycles later, rsp_data=12.
//  2 req0 SUB 10,3 and req1 XOR 0xF0,0xFF same cycle after reset -> req0 first (7), then req1 (0x0F).
//  3 both requesters continuously valid, 4 ops -> completion order 0,1,0,1; never two ready bits set.
//  4 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=0 throughout.
//  5 rst_n=0 during EXEC -> next cycle rsp_valid=0, IDLE, rr_ptr=0; no stale response afterwards.
//  6 req1 SRA 0x80000000,4 -> 0xF8000000; with ALU_B2B_EN, back-to-back ops complete 2 cycles apart (3 without).

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the alu_share_arb slice.
// XLEN, ALU opcodes and the sequencer state encoding.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: requester-side request/response bus.
// master = requesters, slave = arbiter; NUM_REQ lanes.
interface alu_share_arb_if
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*XLEN-1:0] req_in1;
  logic [NUM_REQ*XLEN-1:0] req_in2;
  logic [NUM_REQ*4-1:0]    req_aluop;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [NUM_REQ-1:0]      rsp_ready;
  logic [XLEN-1:0]         rsp_data;

  modport master (
    output req_valid, req_in1, req_in2,
    output req_aluop, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_in1, req_in2,
    input  req_aluop, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/alu_share_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
// valid, ptr -> one-hot grant (first valid at/after ptr), any_grant.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic                 any_grant
);

  localparam int PW = $clog2(N);

  // Walk from farthest to nearest so the
  // nearest valid at/after ptr wins last.
  always_comb begin
    logic [PW-1:0] idx;
    grant = '0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

  assign any_grant = |valid;

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU among NUM_REQ requesters.
// Ports: clk, rst_n (sync, active low), bus (slave: req_*/rsp_*),
// alu_in1/alu_in2/alu_aluop to the ALU, alu_out from it.
// Option: ALU_B2B_EN lets RESP hand off straight to a new EXEC.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arb_if.slave       bus,
  output logic [XLEN-1:0]      alu_in1,
  output logic [XLEN-1:0]      alu_in2,
  output logic [3:0]           alu_aluop,
  input  logic [XLEN-1:0]      alu_out
);

  localparam int PW = $clog2(NUM_REQ);

  arb_state_e state, nxt;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      owner;
  logic [PW-1:0]      nxt_ptr;
  logic [PW-1:0]      pick_ptr;
  logic [PW-1:0]      gidx;
  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic               grant_en;
  logic               accept;
  logic               rsp_hs;
  logic [XLEN-1:0]    data_q;
  logic [XLEN-1:0]    sel_in1;
  logic [XLEN-1:0]    sel_in2;
  logic [3:0]         sel_op;

  assign nxt_ptr = (owner == PW'(NUM_REQ - 1))
                 ? '0 : owner + PW'(1);

  assign rsp_hs = (state == RESP)
               && bus.rsp_ready[owner];

  // With back-to-back enabled, the RESP cycle
  // arbitrates with the post-completion pointer.
  always_comb begin
    pick_ptr = rr_ptr;
    grant_en = (state == IDLE);
`ifdef ALU_B2B_EN
    if (state == RESP) begin
      pick_ptr = nxt_ptr;
      grant_en = rsp_hs;
    end
`endif
  end

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .valid     (bus.req_valid),
    .ptr       (pick_ptr),
    .grant     (grant),
    .any_grant (any_grant)
  );

  assign accept        = grant_en && any_grant;
  assign bus.req_ready = accept ? grant : '0;
  assign bus.rsp_data  = data_q;

  always_comb begin
    gidx    = '0;
    sel_in1 = '0;
    sel_in2 = '0;
    sel_op  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx    = PW'(i);
        sel_in1 = bus.req_in1[i*XLEN +: XLEN];
        sel_in2 = bus.req_in2[i*XLEN +: XLEN];
        sel_op  = bus.req_aluop[i*4 +: 4];
      end
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i] = (state == RESP)
                      && (owner == PW'(i));
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = EXEC;
      EXEC:    nxt = RESP;
      RESP:    if (rsp_hs) nxt = accept ? EXEC : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_aluop <= ALU_ADD;
      data_q    <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        alu_in1   <= sel_in1;
        alu_in2   <= sel_in2;
        alu_aluop <= sel_op;
        owner     <= gidx;
      end
      if (state == EXEC) data_q <= alu_out;
      if (rsp_hs) rr_ptr <= nxt_ptr;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed bench for alu_share_arb with a
// response scoreboard; drives a reference ALU on alu_* ports.
module tb_alu_share_arb;
  import alu_pkg::*;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct packed {
    logic [1:0]  own;
    logic [31:0] d;
  } exp_t;

`ifdef ALU_B2B_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_aluop;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  exp_t sbq[$];
  op_t  q0[$];
  op_t  q1[$];
  int   done_t[$];

  alu_share_arb_if #(.NUM_REQ(2)) bus ();

  alu_share_arb #(.NUM_REQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_aluop (alu_aluop),
    .alu_out   (alu_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    alu_out = '0;
    case (alu_aluop)
      ALU_ADD:  alu_out = alu_in1 + alu_in2;
      ALU_SUB:  alu_out = alu_in1 - alu_in2;
      ALU_SLL:  alu_out = alu_in1 << alu_in2[4:0];
      ALU_SLT:  alu_out = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
      ALU_SLTU: alu_out = {31'd0, alu_in1 < alu_in2};
      ALU_XOR:  alu_out = alu_in1 ^ alu_in2;
      ALU_SRL:  alu_out = alu_in1 >> alu_in2[4:0];
      ALU_SRA:  alu_out = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
      ALU_OR:   alu_out = alu_in1 | alu_in2;
      ALU_AND:  alu_out = alu_in1 & alu_in2;
      default:  alu_out = '0;
    endcase
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(int r, op_t o);
    bus.req_valid[r]        = 1'b1;
    bus.req_in1[r*32 +: 32] = o.a;
    bus.req_in2[r*32 +: 32] = o.b;
    bus.req_aluop[r*4 +: 4] = o.op;
  endtask

  task automatic clr_req(int r);
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Returns just after the accepting clock edge.
  task automatic wait_ready(int r);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready[r] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept_r%0d", r), 32'(bus.req_ready[r]), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sbq.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("sb_drained", 32'(sbq.size()), 0);
  endtask

  // Both requesters present their queued ops and
  // advance whenever their ready bit is seen.
  task automatic drive_all();
    int n = 0;
    logic [1:0] rdy;
    op_t dummy;
    if (q0.size() != 0) set_req(0, q0[0]);
    if (q1.size() != 0) set_req(1, q1[0]);
    while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
      @(negedge clk);
      rdy = bus.req_ready;
      n++;
      @(posedge clk);
      #1;
      if (rdy[0]) begin
        dummy = q0.pop_front();
        if (q0.size() != 0) set_req(0, q0[0]);
        else clr_req(0);
      end
      if (rdy[1]) begin
        dummy = q1.pop_front();
        if (q1.size() != 0) set_req(1, q1[0]);
        else clr_req(1);
      end
    end
    chk("drive_done", 32'(q0.size() + q1.size()), 0);
  endtask

  initial begin
    exp_t e;
    logic [1:0] hs;
    bus.req_valid = '0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    bus.req_aluop = '0;
    bus.rsp_ready = 2'b11;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          chk("onehot",
              32'($countones(bus.req_ready) <= 1
               && $countones(bus.rsp_valid) <= 1), 1);
          hs = bus.rsp_valid & bus.rsp_ready;
          if (hs != 2'b00) begin
            chk("rsp_expected", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
              e = sbq.pop_front();
              chk("sb_owner", 32'(bus.rsp_valid), 32'(e.own));
              chk("sb_data", bus.rsp_data, e.d);
              done_t.push_back(cyc);
            end
          end
        end
      end
    join_none

    // reset values
    do_reset();
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_alu_in1", alu_in1, 0);
    chk("rst_alu_in2", alu_in2, 0);
    chk("rst_alu_op", 32'(alu_aluop), 0);
    @(posedge clk);
    #1;

    // 1: ADD latency
    set_req(0, '{ALU_ADD, 32'd5, 32'd7});
    sbq.push_back('{2'b01, 32'd12});
    @(negedge clk);
    chk("t1_ready", 32'(bus.req_ready), 32'b01);
    @(posedge clk);
    #1 clr_req(0);
    @(negedge clk);
    chk("t1_exec_rv", 32'(bus.rsp_valid), 0);
    chk("t1_exec_rr", 32'(bus.req_ready), 0);
    @(negedge clk);
    chk("t1_resp_rv", 32'(bus.rsp_valid), 32'b01);
    chk("t1_resp_d", bus.rsp_data, 32'd12);
    wait_empty();

    // 2: simultaneous requests after reset
    do_reset();
    sbq.push_back('{2'b01, 32'd7});
    sbq.push_back('{2'b10, 32'h0000_000F});
    q0.push_back('{ALU_SUB, 32'd10, 32'd3});
    q1.push_back('{ALU_XOR, 32'hF0, 32'hFF});
    drive_all();
    wait_empty();

    // 3: continuous valids, order and spacing
    do_reset();
    done_t.delete();
    sbq.push_back('{2'b01, 32'd3});
    sbq.push_back('{2'b10, 32'hFF});
    sbq.push_back('{2'b01, 32'd16});
    sbq.push_back('{2'b10, 32'h3C});
    q0.push_back('{ALU_ADD, 32'd1, 32'd2});
    q0.push_back('{ALU_SLL, 32'd1, 32'd4});
    q1.push_back('{ALU_OR, 32'hF0, 32'h0F});
    q1.push_back('{ALU_AND, 32'hFF, 32'h3C});
    drive_all();
    wait_empty();
    chk("t3_ndone", 32'(done_t.size()), 4);
    if (done_t.size() == 4) begin
      for (int i = 1; i < 4; i++)
        chk($sformatf("t3_gap%0d", i),
            32'(done_t[i] - done_t[i-1]), 32'(GAP));
    end

    // 4+6: stalled response (SRA), non-owner rsp_ready ignored
    do_reset();
    bus.rsp_ready = 2'b01;
    set_req(1, '{ALU_SRA, 32'h8000_0000, 32'd4});
    sbq.push_back('{2'b10, 32'hF800_0000});
    wait_ready(1);
    clr_req(1);
    set_req(0, '{ALU_ADD, 32'd100, 32'd23});
    sbq.push_back('{2'b01, 32'd123});
    @(negedge clk);
    chk("t4_exec_rr", 32'(bus.req_ready), 0);
    repeat (5) begin
      @(negedge clk);
      chk("t4_rv", 32'(bus.rsp_valid), 32'b10);
      chk("t4_data", bus.rsp_data, 32'hF800_0000);
      chk("t4_rr", 32'(bus.req_ready), 0);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 2'b11;
    wait_ready(0);
    clr_req(0);
    wait_empty();

    // 5: reset during EXEC
    do_reset();
    set_req(0, '{ALU_XOR, 32'd3, 32'd5});
    sbq.push_back('{2'b01, 32'd6});
    wait_ready(0);
    clr_req(0);
    wait_empty();
    set_req(1, '{ALU_ADD, 32'd1, 32'd1});
    wait_ready(1);
    clr_req(1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5_rv", 32'(bus.rsp_valid), 0);
      chk("t5_data", bus.rsp_data, 0);
    end
    @(posedge clk);
    #1;
    set_req(0, '{ALU_SLTU, 32'd1, 32'd2});
    set_req(1, '{ALU_SLT, 32'hFFFF_FFFF, 32'd0});
    sbq.push_back('{2'b01, 32'd1});
    sbq.push_back('{2'b10, 32'd1});
    @(negedge clk);
    chk("t5_ptr0", 32'(bus.req_ready), 32'b01);
    @(posedge clk);
    #1 clr_req(0);
    wait_ready(1);
    clr_req(1);
    wait_empty();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
